// File: rtl/fd_inst_buffer.sv
// fd_inst_buffer
//   Fetch-to-decode instruction buffer. A small circular FIFO that holds
//   {pc, pc+4, instr} triples between the fetch stage and decode. Both sides
//   use a valid/ready handshake. f_stall gates the PC register enable, and
//   flush discards every in-flight entry when the front end is redirected.
//
// Ports
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   f_valid               fetch presents a valid pc/instr this cycle
//   f_pc, f_pc_plus4      pc and pc+4 of the presented instruction
//   f_instr               instruction word from instruction memory
//   f_ready / f_stall     buffer can accept an entry / inverse, gates the PC enable
//   flush                 drop all entries and any push this cycle
//   d_valid               head entry is valid toward decode
//   d_pc, d_pc_plus4      head entry pc / pc+4 (zero when empty)
//   d_instr               head entry instruction (NOP_INSTR when empty)
//   d_ready               decode consumes the head entry this cycle
//   occupancy             current number of stored entries
module fd_inst_buffer #(
  parameter int          NUM_BITS  = 32,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         f_valid,
  input  logic [NUM_BITS-1:0]          f_pc,
  input  logic [NUM_BITS-1:0]          f_pc_plus4,
  input  logic [31:0]                  f_instr,
  output logic                         f_ready,
  output logic                         f_stall,
  input  logic                         flush,
  output logic                         d_valid,
  output logic [NUM_BITS-1:0]          d_pc,
  output logic [NUM_BITS-1:0]          d_pc_plus4,
  output logic [31:0]                  d_instr,
  input  logic                         d_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [NUM_BITS-1:0] mem_pc    [DEPTH];
  logic [NUM_BITS-1:0] mem_pc4   [DEPTH];
  logic [31:0]         mem_instr [DEPTH];

  // Tracks which slots hold an entry that was actually pushed; only the
  // assertions below look at it.
  logic [DEPTH-1:0]    slot_written;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic push;
  logic pop;

  // Wrap by explicit compare so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
  endfunction

  // Handshake status comes only from the registered count, so there is no
  // combinational path from d_ready to f_ready.
  assign f_ready   = (count != FULL_CNT);
  assign f_stall   = ~f_ready;
  assign d_valid   = (count != '0);
  assign occupancy = count;

  // Flush overrides both sides of the handshake.
  assign push = f_valid & f_ready & ~flush;
  assign pop  = d_valid & d_ready & ~flush;

  // Head slot is shown only while valid; otherwise decode sees a NOP at pc 0.
  assign d_pc       = d_valid ? mem_pc[rd_ptr]    : '0;
  assign d_pc_plus4 = d_valid ? mem_pc4[rd_ptr]   : '0;
  assign d_instr    = d_valid ? mem_instr[rd_ptr] : NOP_INSTR;

  // Pointer and count state. A flush returns everything to the empty
  // position; a simultaneous push and pop moves both pointers while the
  // count stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage has no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= f_pc;
      mem_pc4[wr_ptr]   <= f_pc_plus4;
      mem_instr[wr_ptr] <= f_instr;
    end
  end

  // Slot bookkeeping for the head-entry assertion. Push and pop never hit the
  // same slot in one cycle because that would need the buffer empty and full
  // at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_written <= '0;
    end else if (flush) begin
      slot_written <= '0;
    end else begin
      if (pop)  slot_written[rd_ptr] <= 1'b0;
      if (push) slot_written[wr_ptr] <= 1'b1;
    end
  end

  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    count <= FULL_CNT);

  a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count == FULL_CNT)));

  a_head_written : assert property (@(posedge clk) disable iff (!rst_n)
    d_valid |-> slot_written[rd_ptr]);

endmodule

// File: tb/tb_fd_inst_buffer.sv
// tb_fd_inst_buffer
//   Bench for fd_inst_buffer (default parameters). A queue holds the entries
//   the buffer should contain; expected outputs are read off that queue.
module tb_fd_inst_buffer;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h00000013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk;
  logic        rst_n;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_pc_plus4;
  logic [31:0] f_instr;
  logic        f_ready;
  logic        f_stall;
  logic        flush;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [31:0] d_pc_plus4;
  logic [31:0] d_instr;
  logic        d_ready;
  logic [1:0]  occupancy;

  int vectors;
  int miscompares;

  entry_t model_q[$];

  fd_inst_buffer #(
    .NUM_BITS (32),
    .DEPTH    (DEPTH),
    .NOP_INSTR(NOP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .f_valid   (f_valid),
    .f_pc      (f_pc),
    .f_pc_plus4(f_pc_plus4),
    .f_instr   (f_instr),
    .f_ready   (f_ready),
    .f_stall   (f_stall),
    .flush     (flush),
    .d_valid   (d_valid),
    .d_pc      (d_pc),
    .d_pc_plus4(d_pc_plus4),
    .d_instr   (d_instr),
    .d_ready   (d_ready),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs derived from the queue contents.
  function automatic logic exp_valid();
    return model_q.size() != 0;
  endfunction

  function automatic logic [31:0] exp_pc();
    return (model_q.size() != 0) ? model_q[0].pc : 32'd0;
  endfunction

  function automatic logic [31:0] exp_pc4();
    return (model_q.size() != 0) ? model_q[0].pc + 32'd4 : 32'd0;
  endfunction

  function automatic logic [31:0] exp_instr();
    return (model_q.size() != 0) ? model_q[0].instr : NOP;
  endfunction

  function automatic logic exp_ready();
    return model_q.size() < DEPTH;
  endfunction

  function automatic logic [1:0] exp_occ();
    return 2'(model_q.size());
  endfunction

  // Called just after a falling edge: drive one cycle, update the queue across
  // the rising edge, and return at the next falling edge.
  task automatic drive(input logic fv, input logic [31:0] pc, input logic [31:0] instr,
                       input logic dr, input logic fl);
    bit     do_push;
    bit     do_pop;
    entry_t e;
    f_valid    = fv;
    f_pc       = pc;
    f_pc_plus4 = pc + 32'd4;
    f_instr    = instr;
    d_ready    = dr;
    flush      = fl;
    do_push = fv && (model_q.size() < DEPTH) && !fl;
    do_pop  = dr && (model_q.size() > 0) && !fl;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (do_pop) model_q.delete(0);
      if (do_push) begin
        e.pc    = pc;
        e.instr = instr;
        model_q.push_back(e);
      end
    end
    @(negedge clk);
    f_valid = 1'b0;
    d_ready = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (d_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_d_valid got %b want 0", d_valid); end
    vectors++; if (d_instr !== NOP) begin miscompares++; $display("[TB] FAIL reset_d_instr got %h want %h", d_instr, NOP); end
    vectors++; if (d_pc !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_d_pc got %h want 0", d_pc); end
    vectors++; if (d_pc_plus4 !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_d_pc_plus4 got %h want 0", d_pc_plus4); end
    vectors++; if (f_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_f_ready got %b want 1", f_ready); end
    vectors++; if (f_stall !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_f_stall got %b want 0", f_stall); end
    vectors++; if (occupancy !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_occupancy got %0d want 0", occupancy); end
    rst_n = 1'b1;
    model_q.delete();
  endtask

  task automatic test_single();
    drive(1'b1, 32'h0, 32'h00500093, 1'b1, 1'b0);
    vectors++; if (d_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL single_d_valid got %b want 1", d_valid); end
    vectors++; if (d_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL single_d_pc got %h want 0", d_pc); end
    vectors++; if (d_pc_plus4 !== 32'h4) begin miscompares++; $display("[TB] FAIL single_d_pc_plus4 got %h want 4", d_pc_plus4); end
    vectors++; if (d_instr !== 32'h00500093) begin miscompares++; $display("[TB] FAIL single_d_instr got %h want 00500093", d_instr); end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    vectors++; if (d_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_drain_valid got %b want 0", d_valid); end
    vectors++; if (d_instr !== NOP) begin miscompares++; $display("[TB] FAIL single_drain_instr got %h want %h", d_instr, NOP); end
  endtask

  task automatic test_full();
    drive(1'b1, 32'h0, 32'h11111111, 1'b0, 1'b0);
    vectors++; if (f_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL full_ready_after_one got %b want 1", f_ready); end
    drive(1'b1, 32'h4, 32'h22222222, 1'b0, 1'b0);
    vectors++; if (f_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL full_f_ready got %b want 0", f_ready); end
    vectors++; if (f_stall !== 1'b1) begin miscompares++; $display("[TB] FAIL full_f_stall got %b want 1", f_stall); end
    vectors++; if (occupancy !== 2'd2) begin miscompares++; $display("[TB] FAIL full_occupancy got %0d want 2", occupancy); end
    drive(1'b1, 32'h8, 32'h33333333, 1'b0, 1'b0);
    vectors++; if (d_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL full_third_ignored_pc got %h want 0", d_pc); end
    vectors++; if (occupancy !== 2'd2) begin miscompares++; $display("[TB] FAIL full_third_ignored_occ got %0d want 2", occupancy); end
  endtask

  task automatic test_drain();
    vectors++; if (d_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL drain_first_pc got %h want 0", d_pc); end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    vectors++; if (d_pc !== 32'h4) begin miscompares++; $display("[TB] FAIL drain_second_pc got %h want 4", d_pc); end
    vectors++; if (d_instr !== 32'h22222222) begin miscompares++; $display("[TB] FAIL drain_second_instr got %h want 22222222", d_instr); end
    vectors++; if (f_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL drain_ready_back got %b want 1", f_ready); end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    vectors++; if (d_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL drain_empty_valid got %b want 0", d_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] pc;
    for (int i = 0; i < 8; i++) begin
      pc = 32'(i * 4);
      drive(1'b1, pc, $urandom, 1'b1, 1'b0);
      vectors++; if (occupancy !== 2'd1) begin miscompares++; $display("[TB] FAIL stream_occ[%0d] got %0d want 1", i, occupancy); end
      vectors++; if (d_pc !== pc) begin miscompares++; $display("[TB] FAIL stream_pc[%0d] got %h want %h", i, d_pc, pc); end
      vectors++; if (d_instr !== exp_instr()) begin miscompares++; $display("[TB] FAIL stream_instr[%0d] got %h want %h", i, d_instr, exp_instr()); end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    vectors++; if (d_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_end_valid got %b want 0", d_valid); end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h0, 32'haaaa0001, 1'b0, 1'b0);
    drive(1'b1, 32'h4, 32'haaaa0002, 1'b0, 1'b0);
    vectors++; if (occupancy !== 2'd2) begin miscompares++; $display("[TB] FAIL flush_pre_occ got %0d want 2", occupancy); end
    drive(1'b1, 32'h100, 32'hbbbb0001, 1'b1, 1'b1);
    vectors++; if (d_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_d_valid got %b want 0", d_valid); end
    vectors++; if (occupancy !== 2'd0) begin miscompares++; $display("[TB] FAIL flush_occupancy got %0d want 0", occupancy); end
    vectors++; if (d_instr !== NOP) begin miscompares++; $display("[TB] FAIL flush_d_instr got %h want %h", d_instr, NOP); end
    drive(1'b1, 32'h200, 32'hcccc0001, 1'b0, 1'b0);
    vectors++; if (d_pc !== 32'h200) begin miscompares++; $display("[TB] FAIL flush_next_pc got %h want 200", d_pc); end
    vectors++; if (d_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_next_valid got %b want 1", d_valid); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    vectors++; if (d_pc !== 32'h200) begin miscompares++; $display("[TB] FAIL flush_no_ghost_pc got %h want 200", d_pc); end
    vectors++; if (occupancy !== 2'd1) begin miscompares++; $display("[TB] FAIL flush_no_ghost_occ got %0d want 1", occupancy); end
  endtask

  task automatic test_async_reset();
    vectors++; if (d_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL areset_pre_valid got %b want 1", d_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (d_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_d_valid got %b want 0", d_valid); end
    vectors++; if (d_instr !== NOP) begin miscompares++; $display("[TB] FAIL areset_d_instr got %h want %h", d_instr, NOP); end
    vectors++; if (occupancy !== 2'd0) begin miscompares++; $display("[TB] FAIL areset_occupancy got %0d want 0", occupancy); end
    model_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++; if (f_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL areset_f_ready got %b want 1", f_ready); end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    vectors++; if (d_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_after_valid got %b want 0", d_valid); end
  endtask

  task automatic test_random();
    logic fv;
    logic dr;
    logic fl;
    for (int i = 0; i < 300; i++) begin
      fv = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 15) == 0);
      drive(fv, {$urandom_range(0, 1023), 2'b00}, $urandom, dr, fl);
      vectors++; if (d_valid !== exp_valid()) begin miscompares++; $display("[TB] FAIL rand_d_valid[%0d] got %b want %b", i, d_valid, exp_valid()); end
      vectors++; if (d_pc !== exp_pc()) begin miscompares++; $display("[TB] FAIL rand_d_pc[%0d] got %h want %h", i, d_pc, exp_pc()); end
      vectors++; if (d_pc_plus4 !== exp_pc4()) begin miscompares++; $display("[TB] FAIL rand_d_pc_plus4[%0d] got %h want %h", i, d_pc_plus4, exp_pc4()); end
      vectors++; if (d_instr !== exp_instr()) begin miscompares++; $display("[TB] FAIL rand_d_instr[%0d] got %h want %h", i, d_instr, exp_instr()); end
      vectors++; if (f_ready !== exp_ready()) begin miscompares++; $display("[TB] FAIL rand_f_ready[%0d] got %b want %b", i, f_ready, exp_ready()); end
      vectors++; if (f_stall !== !exp_ready()) begin miscompares++; $display("[TB] FAIL rand_f_stall[%0d] got %b want %b", i, f_stall, !exp_ready()); end
      vectors++; if (occupancy !== exp_occ()) begin miscompares++; $display("[TB] FAIL rand_occupancy[%0d] got %0d want %0d", i, occupancy, exp_occ()); end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    f_valid     = 1'b0;
    f_pc        = 32'd0;
    f_pc_plus4  = 32'd0;
    f_instr     = 32'd0;
    d_ready     = 1'b0;
    flush       = 1'b0;
    test_reset();
    test_single();
    test_full();
    test_drain();
    test_stream();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
